// File: rtl/seg7_pkg.sv
// Shared 7-segment glyphs (active-high, {g,f,e,d,c,b,a}) and the BCD digit limit.
package seg7_pkg;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/bcd_counter_scan_if.sv
// Control inputs and counter/display outputs of the BCD counter-scan block.
interface bcd_counter_scan_if #(
    parameter int DIGITS = 4
);
    logic                  iEn;
    logic                  iUp;
    logic                  iLoad;
    logic [4*DIGITS-1:0]   iD;
    logic [4*DIGITS-1:0]   oQ;
    logic                  oCarry;
    logic [6:0]            oDisplay;
    logic [DIGITS-1:0]     oAnode;

    modport master (
        output iEn, iUp, iLoad, iD,
        input  oQ, oCarry, oDisplay, oAnode
    );

    modport slave (
        input  iEn, iUp, iLoad, iD,
        output oQ, oCarry, oDisplay, oAnode
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder; non-BCD codes render blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    // Glyph lookup, active-high segments
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with clamped parallel load, wrap pulse and
// a time-multiplexed 7-segment scan driver.
module bcd_counter_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   CLK,
    input  logic                   rst,
    bcd_counter_scan_if.slave      bus
);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0][3:0] q_q, q_d;
    logic [DIGITS-1:0][3:0] cnt_nxt, ld_val;
    logic [DIGITS:0]        chain;
    logic                   carry_q, carry_d;
    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [6:0]             disp_q, disp_d;
    logic [DIGITS-1:0]      anode_q, anode_d;
    logic [6:0]             glyph;
    logic [DIGITS-1:0]      anode_hot;

    // chain[k] = every lower digit is at its wrap value, so digit k steps this cycle
    assign chain[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign ld_val[k]   = (bus.iD[4*k +: 4] > BCD_MAX) ? BCD_MAX : bus.iD[4*k +: 4];
        assign chain[k+1]  = chain[k] & (bus.iUp ? (q_q[k] == BCD_MAX) : (q_q[k] == 4'd0));
        assign cnt_nxt[k]  = !chain[k] ? q_q[k] :
                             bus.iUp   ? ((q_q[k] == BCD_MAX) ? 4'd0 : q_q[k] + 4'd1) :
                                         ((q_q[k] == 4'd0)    ? BCD_MAX : q_q[k] - 4'd1);
    end

    // Counter next state: load beats count; a wrap out of the top digit pulses carry
    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        if (bus.iLoad) begin
            q_d = ld_val;
        end else if (bus.iEn) begin
            q_d     = cnt_nxt;
            carry_d = chain[DIGITS];
        end
    end

    // Scan prescaler and digit index, free-running
    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    seg7_decode u_dec (
        .bcd (q_q[idx_q]),
        .seg (glyph)
    );

    // Display outputs sampled from the current index and count, polarity applied here
    always_comb begin
        anode_hot = DIGITS'(1) << idx_q;
        disp_d    = SEG_ACTIVE_LOW ? ~glyph : glyph;
        anode_d   = SEG_ACTIVE_LOW ? ~anode_hot : anode_hot;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (rst) begin
            q_q     <= '0;
            carry_q <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            disp_q  <= SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
            anode_q <= SEG_ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            anode_q <= anode_d;
        end
    end

    assign bus.oQ       = q_q;
    assign bus.oCarry   = carry_q;
    assign bus.oDisplay = disp_q;
    assign bus.oAnode   = anode_q;
endmodule

// File: tb/tb_bcd_counter_scan.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// decimal-arithmetic reference model of the counter and scan.
module tb_bcd_counter_scan;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int MAXV = 9999;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    bcd_counter_scan_if #(.DIGITS(D)) bus ();

    bcd_counter_scan #(.DIGITS(D), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    int q_m      = 0;
    int prev_q   = 0;
    int t_m      = 0;
    bit carry_m  = 1'b0;

    function automatic int clamp_val(logic [15:0] d);
        int v = 0;
        for (int k = 3; k >= 0; k--) begin
            int n;
            n = int'(d[4*k +: 4]);
            if (n > 9) n = 9;
            v = v * 10 + n;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        int p = 1;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph_hi(int n);
        case (n)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int scan_idx();
        return (t_m == 0) ? 0 : ((t_m - 1) / SD) % D;
    endfunction

    function automatic logic [6:0] exp_disp();
        int p = 1;
        for (int k = 0; k < scan_idx(); k++) p = p * 10;
        return ~glyph_hi((prev_q / p) % 10);
    endfunction

    function automatic logic [3:0] exp_anode();
        logic [3:0] a;
        a = 4'b0001 << scan_idx();
        return ~a;
    endfunction

    // one clock edge: update the model from the sampled inputs, then settle
    task automatic tick();
        @(posedge CLK);
        if (rst) begin
            q_m = 0; prev_q = 0; t_m = 0; carry_m = 1'b0;
        end else begin
            prev_q  = q_m;
            t_m++;
            carry_m = 1'b0;
            if (bus.iLoad) begin
                q_m = clamp_val(bus.iD);
            end else if (bus.iEn) begin
                if (bus.iUp) begin
                    if (q_m == MAXV) begin q_m = 0; carry_m = 1'b1; end
                    else q_m = q_m + 1;
                end else begin
                    if (q_m == 0) begin q_m = MAXV; carry_m = 1'b1; end
                    else q_m = q_m - 1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(bit r, bit ld, bit en, bit up, logic [15:0] d);
        rst = r; bus.iLoad = ld; bus.iEn = en; bus.iUp = up; bus.iD = d;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 16'h0);
        tick(); tick();
        checks++; if (bus.oQ !== 16'h0000) begin failures++; $display("FAIL reset_q got=%h exp=0000", bus.oQ); end
        checks++; if (bus.oCarry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", bus.oCarry); end
        checks++; if (bus.oAnode !== 4'b1110) begin failures++; $display("FAIL reset_anode got=%b exp=1110", bus.oAnode); end
        checks++; if (bus.oDisplay !== 7'b1000000) begin failures++; $display("FAIL reset_disp got=%b exp=1000000", bus.oDisplay); end
    endtask

    task automatic test_load_up();
        drive(0, 1, 0, 1, 16'h0998); tick();
        checks++; if (bus.oQ !== 16'h0998) begin failures++; $display("FAIL load_q got=%h exp=0998", bus.oQ); end
        drive(0, 0, 1, 1, 16'h0); tick();
        checks++; if (bus.oQ !== 16'h0999) begin failures++; $display("FAIL up1_q got=%h exp=0999", bus.oQ); end
        checks++; if (bus.oCarry !== 1'b0) begin failures++; $display("FAIL up1_carry got=%b exp=0", bus.oCarry); end
        tick();
        checks++; if (bus.oQ !== 16'h1000) begin failures++; $display("FAIL up2_ripple_q got=%h exp=1000", bus.oQ); end
        checks++; if (bus.oCarry !== 1'b0) begin failures++; $display("FAIL up2_carry got=%b exp=0", bus.oCarry); end
    endtask

    task automatic test_wrap_up();
        drive(0, 1, 0, 1, 16'h9999); tick();
        drive(0, 0, 1, 1, 16'h0); tick();
        checks++; if (bus.oQ !== 16'h0000) begin failures++; $display("FAIL wrapup_q got=%h exp=0000", bus.oQ); end
        checks++; if (bus.oCarry !== 1'b1) begin failures++; $display("FAIL wrapup_carry got=%b exp=1", bus.oCarry); end
        drive(0, 0, 0, 1, 16'h0); tick();
        checks++; if (bus.oCarry !== 1'b0) begin failures++; $display("FAIL wrapup_carry_drop got=%b exp=0", bus.oCarry); end
        checks++; if (bus.oQ !== 16'h0000) begin failures++; $display("FAIL hold_q got=%h exp=0000", bus.oQ); end
    endtask

    task automatic test_wrap_down_clamp();
        drive(0, 1, 0, 0, 16'h0000); tick();
        drive(0, 0, 1, 0, 16'h0); tick();
        checks++; if (bus.oQ !== 16'h9999) begin failures++; $display("FAIL wrapdn_q got=%h exp=9999", bus.oQ); end
        checks++; if (bus.oCarry !== 1'b1) begin failures++; $display("FAIL wrapdn_carry got=%b exp=1", bus.oCarry); end
        drive(0, 1, 0, 0, 16'hF3A1); tick();
        checks++; if (bus.oQ !== 16'h9391) begin failures++; $display("FAIL clamp_q got=%h exp=9391", bus.oQ); end
        checks++; if (bus.oCarry !== 1'b0) begin failures++; $display("FAIL load_carry got=%b exp=0", bus.oCarry); end
        drive(0, 0, 1, 0, 16'h0); tick();
        checks++; if (bus.oQ !== 16'h9390) begin failures++; $display("FAIL down_q got=%h exp=9390", bus.oQ); end
        tick();
        checks++; if (bus.oQ !== 16'h9389) begin failures++; $display("FAIL borrow_q got=%h exp=9389", bus.oQ); end
    endtask

    task automatic test_scan();
        int seen [4];
        logic [3:0] a;
        drive(1, 0, 0, 0, 16'h0); tick();
        drive(0, 1, 0, 0, 16'h1234); tick();
        drive(0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) seen[i] = 0;
        for (int c = 0; c < 17; c++) begin
            tick();
            checks++; if (bus.oAnode !== exp_anode() || bus.oDisplay !== exp_disp()) begin
                failures++;
                $display("FAIL scan_c%0d got=%b/%b exp=%b/%b", c, bus.oAnode, bus.oDisplay, exp_anode(), exp_disp());
            end
            a = ~bus.oAnode;
            if (c >= 1) for (int i = 0; i < 4; i++) if (a == (4'b0001 << i)) seen[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] != SD) begin failures++; $display("FAIL scan_dwell_d%0d got=%0d exp=%0d", i, seen[i], SD); end
        end
    endtask

    task automatic test_priority();
        drive(0, 1, 0, 1, 16'h0500); tick();
        drive(0, 1, 1, 1, 16'h4321); tick();
        checks++; if (bus.oQ !== 16'h4321) begin failures++; $display("FAIL prio_load_q got=%h exp=4321", bus.oQ); end
        drive(1, 1, 1, 1, 16'h7777); tick();
        checks++; if (bus.oQ !== 16'h0000) begin failures++; $display("FAIL prio_rst_q got=%h exp=0000", bus.oQ); end
        checks++; if (bus.oAnode !== 4'b1110) begin failures++; $display("FAIL prio_rst_anode got=%b exp=1110", bus.oAnode); end
        drive(0, 0, 0, 1, 16'h0);
        for (int c = 0; c < SD; c++) tick();
        checks++; if (bus.oAnode !== 4'b1110) begin failures++; $display("FAIL prio_rst_idx got=%b exp=1110", bus.oAnode); end
        tick();
        checks++; if (bus.oAnode !== 4'b1101) begin failures++; $display("FAIL prio_rst_step got=%b exp=1101", bus.oAnode); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 8), $urandom_range(0, 1), 16'($urandom));
            if ($urandom_range(0, 29) == 0) bus.iD = ($urandom_range(0, 1) != 0) ? 16'h9999 : 16'h0000;
            tick();
            checks++; if (bus.oQ !== to_bcd(q_m) || bus.oCarry !== carry_m) begin
                failures++;
                $display("FAIL rand_cnt c=%0d got=%h/%b exp=%h/%b", c, bus.oQ, bus.oCarry, to_bcd(q_m), carry_m);
            end
            checks++; if (bus.oAnode !== exp_anode() || bus.oDisplay !== exp_disp()) begin
                failures++;
                $display("FAIL rand_scan c=%0d got=%b/%b exp=%b/%b", c, bus.oAnode, bus.oDisplay, exp_anode(), exp_disp());
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 16'h0);
        test_reset();
        test_load_up();
        test_wrap_up();
        test_wrap_down_clamp();
        test_scan();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
